// File: rtl/act_seq_pkg.sv
// Shared definitions for the activation sequencer: FSM state type,
// default widths and the tile-count helper.
package act_seq_pkg;

  localparam int DEF_NUM_ROWS = 32;
  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_BATCH_W  = 6;
  localparam int TILE_CNT_W   = 8;
  localparam int ROW_IDX_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

  // Index of the final tile; a tile count of zero runs a single tile.
  function automatic logic [TILE_CNT_W-1:0] final_tile_idx(input logic [TILE_CNT_W-1:0] num_tiles);
    return (num_tiles == '0) ? '0 : num_tiles - 1'b1;
  endfunction

endpackage

// File: rtl/act_seq_if.sv
// Layer-command handshake between the host and the activation sequencer.
// The master drives a command and holds it until cmd_ready is seen high.
interface act_seq_cmd_if
  import act_seq_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BATCH_W = DEF_BATCH_W
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_addr_start;
  logic [ADDR_W-1:0]     cmd_stride;
  logic [ROW_IDX_W-1:0]  cmd_last_row;
  logic [BATCH_W-1:0]    cmd_batch;
  logic [TILE_CNT_W-1:0] cmd_num_tiles;

  modport master (
    output cmd_valid, cmd_addr_start, cmd_stride, cmd_last_row, cmd_batch, cmd_num_tiles,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr_start, cmd_stride, cmd_last_row, cmd_batch, cmd_num_tiles,
    output cmd_ready
  );

endinterface

// File: rtl/act_drain_detect.sv
// Detects the end of a tile drain: row 0 must have been seen high since
// DRAIN was entered, and the tile completes on the first low cycle after.
// Optional watchdog (ACT_SEQ_WATCHDOG_EN) fires after WDOG_LIMIT drain cycles.
module act_drain_detect
  import act_seq_pkg::*;
#(
  parameter int WDOG_LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic row0_valid,
  output logic tile_done,
  output logic wdog_fire
);

  logic seen_high;

  // Remember that row 0 went high during the current drain; cleared outside DRAIN.
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      seen_high <= 1'b0;
    end else if (row0_valid) begin
      seen_high <= 1'b1;
    end
  end

  assign tile_done = active && seen_high && !row0_valid;

`ifdef ACT_SEQ_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_LIMIT + 1);

  logic [CNT_W-1:0] drain_cnt;

  // Count cycles spent in DRAIN, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      drain_cnt <= '0;
    end else if (drain_cnt != CNT_W'(WDOG_LIMIT)) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  assign wdog_fire = active && (drain_cnt == CNT_W'(WDOG_LIMIT));
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = (WDOG_LIMIT == 0);
  assign wdog_fire = 1'b0;
`endif

endmodule

// File: rtl/act_seq_ctrl.sv
// Activation sequencer: accepts a layer command, issues one start pulse per
// tile to the activation bank with a strided address, waits for each tile to
// drain, then pulses done. abort (or the optional ACT_SEQ_WATCHDOG_EN
// watchdog) cancels the layer with an aborted pulse.
module act_seq_ctrl
  import act_seq_pkg::*;
#(
  parameter int NUM_ROWS   = DEF_NUM_ROWS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BATCH_W    = DEF_BATCH_W,
  parameter int WDOG_LIMIT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  act_seq_cmd_if.slave         cmd,
  input  logic                 abort,
  input  logic                 array_ready,
  input  logic [NUM_ROWS-1:0]  activation_in_valid,
  output logic                 start,
  output logic [ROW_IDX_W-1:0] last_row,
  output logic [ADDR_W-1:0]    addr_start,
  output logic [BATCH_W-1:0]   batch,
  output logic                 host_lock,
  output logic                 done,
  output logic                 aborted
);

  seq_state_t            state;
  seq_state_t            state_nxt;
  logic                  ready_en;
  logic                  accept;
  logic                  cancel;
  logic                  tile_advance;
  logic                  tile_done;
  logic                  wdog_fire;
  logic [TILE_CNT_W-1:0] tile_idx;
  logic [TILE_CNT_W-1:0] final_idx;
  logic [ADDR_W-1:0]     stride_q;
  logic                  unused_upper_rows;

  // Only row 0 paces the drain; the other rows are carried for the bank's benefit.
  assign unused_upper_rows = ^activation_in_valid;

  act_drain_detect #(
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_drain_detect (
    .clk        (clk),
    .reset      (reset),
    .active     (state == DRAIN),
    .row0_valid (activation_in_valid[0]),
    .tile_done  (tile_done),
    .wdog_fire  (wdog_fire)
  );

  assign cancel    = abort || wdog_fire;
  assign host_lock = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Hold cmd_ready low through reset and the cycle it deasserts.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Next-state and pulse outputs; cancel overrides start, done and tile completion.
  always_comb begin
    state_nxt     = state;
    cmd.cmd_ready = 1'b0;
    accept        = 1'b0;
    tile_advance  = 1'b0;
    start         = 1'b0;
    done          = 1'b0;
    aborted       = 1'b0;
    case (state)
      IDLE: begin
        cmd.cmd_ready = ready_en;
        if (cmd.cmd_valid && ready_en) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cancel) begin
          aborted   = 1'b1;
          state_nxt = IDLE;
        end else if (array_ready) begin
          start     = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cancel) begin
          aborted   = 1'b1;
          state_nxt = IDLE;
        end else if (tile_done) begin
          tile_advance = 1'b1;
          state_nxt    = (tile_idx == final_idx) ? DONE : ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (cancel) begin
          aborted = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the command and step the tile address by accumulating the stride,
  // which wraps naturally at the address width.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_start <= '0;
      stride_q   <= '0;
      last_row   <= '0;
      batch      <= '0;
      final_idx  <= '0;
      tile_idx   <= '0;
    end else if (accept) begin
      addr_start <= cmd.cmd_addr_start;
      stride_q   <= cmd.cmd_stride;
      last_row   <= cmd.cmd_last_row;
      batch      <= cmd.cmd_batch;
      final_idx  <= final_tile_idx(cmd.cmd_num_tiles);
      tile_idx   <= '0;
    end else if (tile_advance) begin
      addr_start <= addr_start + stride_q;
      tile_idx   <= tile_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_act_seq_ctrl.sv
// Directed testbench for act_seq_ctrl with a tile scoreboard: every command
// pushes its expected per-tile (addr, last_row, batch) and each start pulse
// pops and compares. Covers ACT_SEQ_WATCHDOG_EN when the macro is defined.
module tb_act_seq_ctrl;
  import act_seq_pkg::*;

  localparam int ADDR_W     = 11;
  localparam int BATCH_W    = 6;
  localparam int NUM_ROWS   = 32;
  localparam int WDOG_LIMIT = 100;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [ROW_IDX_W-1:0] last_row;
    logic [BATCH_W-1:0]   batch;
  } tile_exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 abort;
  logic                 array_ready;
  logic [NUM_ROWS-1:0]  activation_in_valid;
  logic                 start;
  logic [ROW_IDX_W-1:0] last_row;
  logic [ADDR_W-1:0]    addr_start;
  logic [BATCH_W-1:0]   batch;
  logic                 host_lock;
  logic                 done;
  logic                 aborted;

  tile_exp_t sb_q[$];
  int checks      = 0;
  int errors      = 0;
  int start_cnt   = 0;
  int done_cnt    = 0;
  int aborted_cnt = 0;
  int s0, d0, a0;

  act_seq_cmd_if #(.ADDR_W(ADDR_W), .BATCH_W(BATCH_W)) cmd_if ();

  act_seq_ctrl #(
    .NUM_ROWS   (NUM_ROWS),
    .ADDR_W     (ADDR_W),
    .BATCH_W    (BATCH_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd                 (cmd_if),
    .abort               (abort),
    .array_ready         (array_ready),
    .activation_in_valid (activation_in_valid),
    .start               (start),
    .last_row            (last_row),
    .addr_start          (addr_start),
    .batch               (batch),
    .host_lock           (host_lock),
    .done                (done),
    .aborted             (aborted)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count the pulse outputs as the DUT presents them at each active edge.
  always @(posedge clk) begin
    if (start === 1'b1) start_cnt++;
    if (done === 1'b1) done_cnt++;
    if (aborted === 1'b1) aborted_cnt++;
  end

  // Hard stop in case the sequence loses sync with the DUT.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one layer command and push the expected tile sequence.
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s,
                               input logic [ROW_IDX_W-1:0] lr, input logic [BATCH_W-1:0] b,
                               input logic [TILE_CNT_W-1:0] n);
    int waited;
    int tiles;
    tile_exp_t e;
    waited = 0;
    @(negedge clk);
    while (cmd_if.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("cmd_ready_idle", cmd_if.cmd_ready, 1);
    cmd_if.cmd_addr_start = a;
    cmd_if.cmd_stride     = s;
    cmd_if.cmd_last_row   = lr;
    cmd_if.cmd_batch      = b;
    cmd_if.cmd_num_tiles  = n;
    cmd_if.cmd_valid      = 1'b1;
    next_cycle();
    cmd_if.cmd_valid = 1'b0;
    tiles = (n == 0) ? 1 : int'(n);
    for (int i = 0; i < tiles; i++) begin
      e.addr     = ADDR_W'(int'(a) + i * int'(s));
      e.last_row = lr;
      e.batch    = b;
      sb_q.push_back(e);
    end
  endtask

  // Wait (bounded) for a start pulse and compare it against the scoreboard head.
  task automatic expect_start(output logic [ADDR_W-1:0] seen_addr);
    int waited;
    tile_exp_t e;
    waited = 0;
    @(negedge clk);
    while (start !== 1'b1 && waited < 10) begin
      next_cycle();
      @(negedge clk);
      waited++;
    end
    checkOutput("start_latency", waited, 0);
    checkOutput("sb_has_entry", (sb_q.size() > 0), 1);
    seen_addr = addr_start;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("addr_start", addr_start, e.addr);
      checkOutput("last_row", last_row, e.last_row);
      checkOutput("batch", batch, e.batch);
    end
  endtask

  // One tile: optional array_ready stall, start, row 0 high then low.
  task automatic run_tile(input int ready_delay, input int high_cycles);
    logic [ADDR_W-1:0] held;
    array_ready = (ready_delay == 0);
    for (int k = 0; k < ready_delay; k++) begin
      @(negedge clk);
      checkOutput("no_start_not_ready", start, 0);
      checkOutput("cmd_ready_busy", cmd_if.cmd_ready, 0);
      if (sb_q.size() > 0) checkOutput("addr_before_start", addr_start, sb_q[0].addr);
      next_cycle();
    end
    array_ready = 1'b1;
    expect_start(held);
    next_cycle();
    array_ready = 1'b0;
    activation_in_valid = '1;
    for (int k = 0; k < high_cycles; k++) begin
      @(negedge clk);
      checkOutput("addr_hold_drain", addr_start, held);
      next_cycle();
    end
    activation_in_valid = '0;
    @(negedge clk);
    next_cycle();
  endtask

  initial begin
    logic [ADDR_W-1:0] tmp_addr;
    reset = 1'b1;
    abort = 1'b0;
    array_ready = 1'b0;
    activation_in_valid = '0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_addr_start = '0;
    cmd_if.cmd_stride = '0;
    cmd_if.cmd_last_row = '0;
    cmd_if.cmd_batch = '0;
    cmd_if.cmd_num_tiles = '0;

    $display("[TB] reset state");
    next_cycle();
    @(negedge clk);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_aborted", aborted, 0);
    checkOutput("rst_host_lock", host_lock, 0);
    checkOutput("rst_last_row", last_row, 0);
    checkOutput("rst_addr_start", addr_start, 0);
    checkOutput("rst_batch", batch, 0);
    checkOutput("rst_cmd_ready", cmd_if.cmd_ready, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("cmd_ready_release_cycle", cmd_if.cmd_ready, 0);
    next_cycle();
    @(negedge clk);
    checkOutput("cmd_ready_after_release", cmd_if.cmd_ready, 1);

    $display("[TB] three-tile layer");
    s0 = start_cnt; d0 = done_cnt;
    applyStimulus(11'd16, 11'd64, 5'd31, 6'd8, 8'd3);
    run_tile(0, 3);
    run_tile(0, 3);
    run_tile(0, 3);
    @(negedge clk);
    checkOutput("layer1_done", done, 1);
    checkOutput("layer1_lock_done", host_lock, 1);
    next_cycle();
    @(negedge clk);
    checkOutput("layer1_idle_lock", host_lock, 0);
    checkOutput("layer1_idle_ready", cmd_if.cmd_ready, 1);
    checkOutput("layer1_starts", start_cnt - s0, 3);
    checkOutput("layer1_dones", done_cnt - d0, 1);

    $display("[TB] array_ready stall, cmd_valid ignored while busy");
    s0 = start_cnt;
    applyStimulus(11'd100, 11'd4, 5'd7, 6'd5, 8'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_addr_start = 11'd500;
    run_tile(10, 2);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("layer2_done", done, 1);
    next_cycle();
    checkOutput("layer2_starts", start_cnt - s0, 1);

    $display("[TB] address wrap");
    applyStimulus(11'd2000, 11'd64, 5'd3, 6'd1, 8'd2);
    run_tile(0, 1);
    run_tile(0, 1);
    @(negedge clk);
    checkOutput("layer3_done", done, 1);
    next_cycle();

    $display("[TB] abort in IDLE");
    abort = 1'b1;
    @(negedge clk);
    checkOutput("idle_abort_ignored", aborted, 0);
    checkOutput("idle_abort_ready", cmd_if.cmd_ready, 1);
    next_cycle();
    abort = 1'b0;

    $display("[TB] abort mid-drain of tile 1");
    a0 = aborted_cnt; d0 = done_cnt;
    applyStimulus(11'd0, 11'd8, 5'd10, 6'd2, 8'd3);
    run_tile(0, 2);
    array_ready = 1'b1;
    expect_start(tmp_addr);
    next_cycle();
    array_ready = 1'b0;
    activation_in_valid = '1;
    next_cycle();
    next_cycle();
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_pulse", aborted, 1);
    checkOutput("abort_no_done", done, 0);
    checkOutput("abort_no_start", start, 0);
    next_cycle();
    abort = 1'b0;
    activation_in_valid = '0;
    @(negedge clk);
    checkOutput("abort_idle_lock", host_lock, 0);
    checkOutput("abort_idle_ready", cmd_if.cmd_ready, 1);
    checkOutput("abort_single_pulse", aborted_cnt - a0, 1);
    checkOutput("abort_dones", done_cnt - d0, 0);
    sb_q.delete();

    $display("[TB] abort coincides with tile completion");
    a0 = aborted_cnt; d0 = done_cnt;
    applyStimulus(11'd40, 11'd0, 5'd1, 6'd1, 8'd1);
    array_ready = 1'b1;
    expect_start(tmp_addr);
    next_cycle();
    array_ready = 1'b0;
    activation_in_valid = '1;
    next_cycle();
    activation_in_valid = '0;
    abort = 1'b1;
    @(negedge clk);
    checkOutput("race_aborted", aborted, 1);
    checkOutput("race_no_done", done, 0);
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    checkOutput("race_no_done_after", done, 0);
    checkOutput("race_idle_lock", host_lock, 0);
    checkOutput("race_dones", done_cnt - d0, 0);

    $display("[TB] drain with row 0 never valid");
    a0 = aborted_cnt;
    applyStimulus(11'd64, 11'd1, 5'd5, 6'd3, 8'd1);
    array_ready = 1'b1;
    expect_start(tmp_addr);
    next_cycle();
    array_ready = 1'b0;
`ifdef ACT_SEQ_WATCHDOG_EN
    begin
      int fired_at;
      fired_at = -1;
      for (int i = 0; i < WDOG_LIMIT + 20; i++) begin
        @(negedge clk);
        if (aborted === 1'b1) begin
          fired_at = i;
          break;
        end
        next_cycle();
      end
      checkOutput("wdog_fire_cycle", fired_at, WDOG_LIMIT);
      next_cycle();
      @(negedge clk);
      checkOutput("wdog_idle_lock", host_lock, 0);
      checkOutput("wdog_pulses", aborted_cnt - a0, 1);
    end
    applyStimulus(11'd300, 11'd7, 5'd2, 6'd4, 8'd1);
    array_ready = 1'b1;
    expect_start(tmp_addr);
    next_cycle();
    array_ready = 1'b0;
    sb_q.delete();
`else
    repeat (WDOG_LIMIT + 20) next_cycle();
    @(negedge clk);
    checkOutput("nowdog_still_locked", host_lock, 1);
    checkOutput("nowdog_no_abort", aborted_cnt - a0, 0);
    next_cycle();
`endif

    $display("[TB] reset during DRAIN, then zero-tile command");
    a0 = aborted_cnt; d0 = done_cnt;
    activation_in_valid = '1;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    checkOutput("mid_rst_start", start, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_aborted", aborted, 0);
    checkOutput("mid_rst_host_lock", host_lock, 0);
    checkOutput("mid_rst_last_row", last_row, 0);
    checkOutput("mid_rst_addr_start", addr_start, 0);
    checkOutput("mid_rst_batch", batch, 0);
    next_cycle();
    reset = 1'b0;
    activation_in_valid = '0;
    sb_q.delete();
    checkOutput("mid_rst_no_aborted", aborted_cnt - a0, 0);
    checkOutput("mid_rst_no_done", done_cnt - d0, 0);
    s0 = start_cnt; d0 = done_cnt;
    applyStimulus(11'd300, 11'd7, 5'd2, 6'd4, 8'd0);
    run_tile(0, 2);
    @(negedge clk);
    checkOutput("zero_tiles_done", done, 1);
    next_cycle();
    @(negedge clk);
    checkOutput("zero_tiles_idle", host_lock, 0);
    checkOutput("zero_tiles_starts", start_cnt - s0, 1);
    checkOutput("zero_tiles_dones", done_cnt - d0, 1);
    checkOutput("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/act_seq_ctrl.md
ACT_SEQ_CTRL -- requirements
Module: act_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 32, meaning activation rows in the bank.
REQ-002 SHALL have parameter ADDR_W, default 11, meaning activation-memory word-address width.
REQ-003 SHALL have parameter BATCH_W, default 6, meaning batch field width.
REQ-004 SHALL have parameter WDOG_LIMIT, default 4096, meaning maximum drain cycles per tile.
REQ-005 SHALL have ports:
 - clk  in  1  sole clock, all logic on posedge.
 - reset  in  1  synchronous active-high reset.
 - cmd_valid  in  1  layer command offered.
 - cmd_ready  out  1  command accepted when high with cmd_valid.
 - cmd_addr_start  in  ADDR_W  base address of tile 0.
 - cmd_stride  in  ADDR_W  address increment per tile.
 - cmd_last_row  in  5  highest active row.
 - cmd_batch  in  BATCH_W  batch size.
 - cmd_num_tiles  in  8  tile count; 0 treated as 1.
 - abort  in  1  synchronous cancel.
 - array_ready  in  1  downstream array can accept a new tile.
 - activation_in_valid  in  NUM_ROWS  per-row valid from activation bank.
 - start  out  1  one-cycle tile start pulse to activation bank.
 - last_row  out  5  to activation bank.
 - addr_start  out  ADDR_W  to activation bank.
 - batch  out  BATCH_W  to activation bank.
 - host_lock  out  1  high while sequencing; host port-A access blocked.
 - done  out  1  one-cycle pulse, layer complete.
 - aborted  out  1  one-cycle pulse, layer cancelled or watchdog fired.

Function
REQ-006 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-007 SHALL drive cmd_ready=1 only in IDLE; acceptance latches all cmd_* fields and moves to ISSUE next cycle.
REQ-008 In ISSUE, SHALL hold start=0 while array_ready=0; when array_ready=1, SHALL pulse start for exactly one cycle and enter DRAIN the next cycle.
REQ-009 SHALL compute addr_start = cmd_addr_start + tile_idx*cmd_stride, truncated modulo 2^ADDR_W (wrap, no error).
REQ-010 SHALL hold last_row, addr_start, batch stable from the start-pulse cycle until DRAIN exits.
REQ-011 In DRAIN, SHALL declare tile complete on the first cycle activation_in_valid[0] is low after having been high since entering DRAIN.
REQ-012 On tile complete, SHALL increment tile_idx; if tile_idx was the final tile, enter DONE, else ISSUE.
REQ-013 DONE SHALL last one cycle, pulse done, then return to IDLE.
REQ-014 host_lock SHALL be high in ISSUE, DRAIN, DONE; low in IDLE.
REQ-015 abort high in any non-IDLE state SHALL enter IDLE next cycle, pulse aborted, suppress start and done that cycle; abort in IDLE SHALL be ignored.
REQ-016 If abort and tile completion coincide, abort SHALL win (no done).
REQ-017 cmd_valid while not IDLE SHALL be ignored (no queuing).

Reset
REQ-018 On reset: state IDLE, tile_idx 0, start 0, done 0, aborted 0, host_lock 0, last_row 0, addr_start 0, batch 0; cmd_ready becomes 1 the cycle after reset deasserts.
REQ-019 Reset mid-layer SHALL discard the layer without pulsing done or aborted.

Configuration
REQ-020 Macro ACT_SEQ_WATCHDOG_EN defined: DRAIN cycle counter; reaching WDOG_LIMIT SHALL behave as abort (IDLE, aborted pulse). Undefined: no counter, DRAIN waits indefinitely.

Structure
REQ-021 Package act_seq_pkg SHALL hold the state enum and default width constants (ADDR_W, BATCH_W, NUM_ROWS, tile-count width).
REQ-022 Sub-module act_drain_detect SHALL contain row-0 seen-high/fall detection and the optional watchdog, outputting tile_done and wdog_fire.

Verification
REQ-023 Cmd addr 16, stride 64, tiles 3, batch 8, last_row 31, array_ready=1 -> three start pulses at addr_start 16, 80, 144; one done pulse after third drain.
REQ-024 array_ready low 10 cycles in ISSUE -> no start for 10 cycles; start on cycle array_ready rises; outputs stable.
REQ-025 Base 2000, stride 64, tiles 2 -> addr_start 2000 then 16 (wrap).
REQ-026 abort asserted mid-DRAIN of tile 1 -> aborted pulse, IDLE next cycle, no done, cmd_ready high.
REQ-027 With ACT_SEQ_WATCHDOG_EN, WDOG_LIMIT 100, valid[0] never asserted -> aborted pulse 100 cycles after DRAIN entry; without macro, controller remains in DRAIN.
REQ-028 Reset asserted during DRAIN -> all outputs zero next cycle; tiles 0 command then runs exactly one tile.
